// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared types and sizing for the multi-cycle multiply/divide unit.
package muldiv_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ITER   = DATA_W;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        FIX  = 2'b10
    } state_e;

    function automatic logic is_div_op(input op_e op);
        return op[1];
    endfunction

    function automatic logic is_signed_op(input op_e op);
        return !op[0];
    endfunction

endpackage

// File: rtl/mul_div_unit_if.sv
// mul_div_unit_if: request, mthi/mtlo and HI/LO result signals between EX stage and the unit.
interface mul_div_unit_if #(
    parameter int unsigned WIDTH = muldiv_pkg::DATA_W
);
    import muldiv_pkg::*;

    logic             start;
    op_e              op;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, A, B, hi_we, lo_we, wdata,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, A, B, hi_we, lo_we, wdata,
        output busy, done, hi, lo
    );

endinterface

// File: rtl/muldiv_sign_fix.sv
// muldiv_sign_fix: conditional two's-complement negation of a {hi, lo} pair or of the whole pair.
module muldiv_sign_fix #(
    parameter int unsigned WIDTH = muldiv_pkg::ITER
) (
    input  logic [2*WIDTH-1:0] din,
    input  logic               neg_wide,
    input  logic               neg_hi,
    input  logic               neg_lo,
    output logic [2*WIDTH-1:0] dout_c
);

    logic [WIDTH-1:0] hi_part;
    logic [WIDTH-1:0] lo_part;

    always_comb begin
        hi_part = din[2*WIDTH-1:WIDTH];
        lo_part = din[WIDTH-1:0];
        if (neg_wide) begin
            dout_c = -din;
        end else begin
            dout_c = {neg_hi ? -hi_part : hi_part, neg_lo ? -lo_part : lo_part};
        end
    end

endmodule

// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative MULT/MULTU/DIV/DIVU with HI/LO registers and mthi/mtlo writes.
// Define MULDIV_EARLY_OUT_EN to let multiplies leave CALC once the remaining multiplier bits are zero.
module mul_div_unit
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = DATA_W
) (
    input logic           clk,
    input logic           reset,
    mul_div_unit_if.slave bus
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);
    localparam int unsigned ACC_W = 2 * WIDTH;

    state_e           state;
    op_e              op_q;
    logic             sign_a;
    logic             sign_b;
    logic             div0;
    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] opnd_a;
    logic [WIDTH-1:0] opnd_b;
    logic [ACC_W-1:0] acc;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;

    logic             in_signed;
    logic [ACC_W-1:0] entry_abs_c;
    logic [ACC_W-1:0] fix_c;
    logic             fix_wide;
    logic             fix_hi;
    logic             fix_lo;

    logic [WIDTH:0]   mul_sum;
    logic [ACC_W-1:0] mul_next;
    logic [WIDTH-1:0] mplier_next;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH-1:0] div_diff;
    logic [ACC_W-1:0] div_next;
    logic [ACC_W-1:0] step_next;
    logic             last_step;

    assign in_signed = is_signed_op(bus.op);

    // Operand magnitudes: |A| in the upper half, |B| in the lower half.
    muldiv_sign_fix #(.WIDTH(WIDTH)) u_entry_fix (
        .din      ({bus.A, bus.B}),
        .neg_wide (1'b0),
        .neg_hi   (in_signed & bus.A[WIDTH-1]),
        .neg_lo   (in_signed & bus.B[WIDTH-1]),
        .dout_c   (entry_abs_c)
    );

    // Divide-by-zero keeps the raw all-ones quotient; the remainder still folds back to A.
    assign fix_wide = (op_q == OP_MULT) & (sign_a ^ sign_b);
    assign fix_hi   = (op_q == OP_DIV) & sign_a;
    assign fix_lo   = (op_q == OP_DIV) & (sign_a ^ sign_b) & ~div0;

    muldiv_sign_fix #(.WIDTH(WIDTH)) u_exit_fix (
        .din      (acc),
        .neg_wide (fix_wide),
        .neg_hi   (fix_hi),
        .neg_lo   (fix_lo),
        .dout_c   (fix_c)
    );

    // One shift-add (multiply) or restoring (divide) step on acc = {hi, lo}.
    always_comb begin
        mul_sum     = {1'b0, acc[ACC_W-1:WIDTH]} + (opnd_b[0] ? {1'b0, opnd_a} : '0);
        mul_next    = {mul_sum, acc[WIDTH-1:1]};
        mplier_next = opnd_b >> 1;
        div_shift   = acc[ACC_W-1:WIDTH-1];
        div_diff    = div_shift[WIDTH-1:0] - opnd_b;
        if (div_shift >= {1'b0, opnd_b}) begin
            div_next = {div_diff, acc[WIDTH-2:0], 1'b1};
        end else begin
            div_next = {acc[ACC_W-2:0], 1'b0};
        end
        last_step = (count == CNT_W'(1));
        step_next = is_div_op(op_q) ? div_next : mul_next;
`ifdef MULDIV_EARLY_OUT_EN
        // Remaining steps would only shift right, so apply them all at once.
        if (!is_div_op(op_q) && (mplier_next == '0)) begin
            last_step = 1'b1;
            step_next = mul_next >> (count - CNT_W'(1));
        end
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            op_q   <= OP_MULT;
            sign_a <= 1'b0;
            sign_b <= 1'b0;
            div0   <= 1'b0;
            count  <= '0;
            opnd_a <= '0;
            opnd_b <= '0;
            acc    <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            hi_q   <= '0;
            lo_q   <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        state  <= CALC;
                        busy_q <= 1'b1;
                        op_q   <= bus.op;
                        sign_a <= in_signed & bus.A[WIDTH-1];
                        sign_b <= in_signed & bus.B[WIDTH-1];
                        div0   <= (bus.B == '0);
                        count  <= CNT_W'(WIDTH);
                        opnd_a <= entry_abs_c[ACC_W-1:WIDTH];
                        opnd_b <= entry_abs_c[WIDTH-1:0];
                        acc    <= is_div_op(bus.op) ? {{WIDTH{1'b0}}, entry_abs_c[ACC_W-1:WIDTH]} : '0;
                    end else begin
                        if (bus.hi_we) hi_q <= bus.wdata;
                        if (bus.lo_we) lo_q <= bus.wdata;
                    end
                end
                CALC: begin
                    acc    <= step_next;
                    opnd_b <= is_div_op(op_q) ? opnd_b : mplier_next;
                    count  <= count - CNT_W'(1);
                    if (last_step) state <= FIX;
                end
                FIX: begin
                    hi_q   <= fix_c[ACC_W-1:WIDTH];
                    lo_q   <= fix_c[WIDTH-1:0];
                    done_q <= 1'b1;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: directed table, corner sequences and random ops checked against an arithmetic model.
// Build with MULDIV_EARLY_OUT_EN defined to exercise the early-out multiply latency bounds.
module tb_mul_div_unit;
    import muldiv_pkg::*;

    localparam int unsigned W   = DATA_W;
    localparam int          LAT = W + 1;

    typedef struct {
        op_e          op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
    } vec_t;

    logic         clk;
    logic         reset;
    int           checks;
    int           errors;
    logic [W-1:0] m_hi;
    logic [W-1:0] m_lo;

    mul_div_unit_if #(.WIDTH(W)) bus ();
    mul_div_unit #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    // Reference: plain 64-bit arithmetic with truncating signed division.
    function automatic void model(input op_e op, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] hi, output logic [W-1:0] lo);
        longint      sa;
        longint      sb;
        longint      q;
        longint      r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            OP_MULTU: p = {32'b0, a} * {32'b0, b};
            OP_MULT:  p = 64'(sa * sb);
            default: begin
                if (b == '0) begin
                    p = {a, {W{1'b1}}};
                end else if (op == OP_DIVU) begin
                    p = {a % b, a / b};
                end else begin
                    q = sa / sb;
                    r = sa % sb;
                    p = {r[W-1:0], q[W-1:0]};
                end
            end
        endcase
        hi = p[63:32];
        lo = p[31:0];
    endfunction

    task automatic check_lat(input string name, input op_e op, input int lat);
`ifdef MULDIV_EARLY_OUT_EN
        if (!is_div_op(op)) begin
            checks++;
            if (lat < 2 || lat > LAT) begin
                errors++;
                $display("FAIL %s: latency %0d, required 2..%0d", name, lat, LAT);
            end
        end else begin
            check(name, 64'(lat), 64'(LAT));
        end
`else
        check(name, 64'(lat), 64'(LAT));
`endif
    endtask

    // Issue one op, poke mthi/mtlo while busy, and return the start-to-done latency.
    task automatic run_op(input string name, input op_e op, input logic [W-1:0] a,
                          input logic [W-1:0] b, output int lat);
        bus.start = 1'b1;
        bus.op    = op;
        bus.A     = a;
        bus.B     = b;
        tick();
        bus.start = 1'b0;
        bus.lo_we = 1'b0;
        bus.hi_we = 1'b0;
        check({name, "_busy"}, 64'(bus.busy), 64'(1));
        check({name, "_lo_after_start"}, 64'(bus.lo), 64'(m_lo));
        lat = 0;
        while (!bus.done && lat < 100) begin
            if (lat == 1) begin
                bus.hi_we = 1'b1;
                bus.lo_we = 1'b1;
                bus.wdata = 32'hBAD0_BAD0;
            end
            tick();
            lat++;
            if (lat == 2) begin
                bus.hi_we = 1'b0;
                bus.lo_we = 1'b0;
            end
            if (!bus.done && (lat == 2 || lat == int'(W / 2))) begin
                check({name, "_hold_hi"}, 64'(bus.hi), 64'(m_hi));
                check({name, "_hold_lo"}, 64'(bus.lo), 64'(m_lo));
            end
        end
        if (!bus.done) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: no done within %0d cycles", name, lat);
        end
    endtask

    task automatic exec(input string name, input op_e op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] exp_hi,
                        input logic [W-1:0] exp_lo, output int lat);
        run_op(name, op, a, b, lat);
        check_lat({name, "_lat"}, op, lat);
        check({name, "_hi"}, 64'(bus.hi), 64'(exp_hi));
        check({name, "_lo"}, 64'(bus.lo), 64'(exp_lo));
        m_hi = exp_hi;
        m_lo = exp_lo;
        tick();
        check({name, "_done_pulse"}, 64'({bus.done, bus.busy}), 64'(0));
    endtask

    initial begin
        vec_t         vecs[10];
        int           lat;
        int           dones;
        int           first;
        op_e          rop;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic [W-1:0] rhi;
        logic [W-1:0] rlo;

        checks    = 0;
        errors    = 0;
        m_hi      = '0;
        m_lo      = '0;
        reset     = 1'b0;
        bus.start = 1'b0;
        bus.op    = OP_MULT;
        bus.A     = '0;
        bus.B     = '0;
        bus.hi_we = 1'b0;
        bus.lo_we = 1'b0;
        bus.wdata = '0;
        repeat (2) tick();
        check("reset_outputs", {30'b0, bus.busy, bus.done, bus.hi, bus.lo}, 64'(0));
        reset = 1'b1;
        tick();

        vecs[0] = '{OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
        vecs[1] = '{OP_MULT,  32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
        vecs[2] = '{OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[3] = '{OP_DIVU,  32'd100,       32'd0,         32'd100,       32'hFFFF_FFFF};
        vecs[4] = '{OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
        vecs[5] = '{OP_DIVU,  32'd100,       32'd7,         32'd2,         32'd14};
        vecs[6] = '{OP_DIV,   32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF};
        vecs[7] = '{OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
        vecs[8] = '{OP_DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD};
        vecs[9] = '{OP_MULTU, 32'd0,         32'h0001_2345, 32'd0,         32'd0};
        foreach (vecs[i]) begin
            exec($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, lat);
        end

        // mthi / mtlo in IDLE
        bus.hi_we = 1'b1;
        bus.wdata = 32'h0000_1234;
        tick();
        bus.hi_we = 1'b0;
        check("mthi", 64'(bus.hi), 64'h1234);
        check("mthi_lo_kept", 64'(bus.lo), 64'(m_lo));
        m_hi = 32'h0000_1234;
        bus.lo_we = 1'b1;
        bus.wdata = 32'h0000_5678;
        tick();
        bus.lo_we = 1'b0;
        check("mtlo", 64'(bus.lo), 64'h5678);
        m_lo = 32'h0000_5678;

        // mtlo alongside start: start wins
        bus.lo_we = 1'b1;
        bus.wdata = 32'hDEAD_BEEF;
        exec("mtlo_vs_start", OP_MULTU, 32'd6, 32'd7, 32'd0, 32'd42, lat);

        // Second start mid-DIVU is ignored
        bus.start = 1'b1;
        bus.op    = OP_DIVU;
        bus.A     = 32'd100;
        bus.B     = 32'd7;
        tick();
        bus.start = 1'b0;
        dones = 0;
        first = 0;
        for (int c = 1; c <= 45; c++) begin
            if (c == 5) begin
                bus.start = 1'b1;
                bus.op    = OP_MULTU;
                bus.A     = 32'd3;
                bus.B     = 32'd3;
            end
            tick();
            bus.start = 1'b0;
            if (bus.done) begin
                dones++;
                if (first == 0) begin
                    first = c;
                    check("restart_hi", 64'(bus.hi), 64'd2);
                    check("restart_lo", 64'(bus.lo), 64'd14);
                end
            end
        end
        check("restart_done_count", 64'(dones), 64'd1);
        check("restart_lat", 64'(first), 64'(LAT));
        check("restart_idle", 64'(bus.busy), 64'd0);
        m_hi = 32'd2;
        m_lo = 32'd14;

        // Reset in cycle 10 of a MULTU
        bus.hi_we = 1'b1;
        bus.wdata = 32'h0000_ABCD;
        tick();
        bus.hi_we = 1'b0;
        bus.start = 1'b1;
        bus.op    = OP_MULTU;
        bus.A     = 32'hFFFF_FFFF;
        bus.B     = 32'hFFFF_FFFF;
        tick();
        bus.start = 1'b0;
        repeat (9) tick();
        reset = 1'b0;
        #1;
        check("midreset_outputs", {30'b0, bus.busy, bus.done, bus.hi, bus.lo}, 64'(0));
        m_hi = '0;
        m_lo = '0;
        tick();
        reset = 1'b1;
        tick();
        exec("after_reset", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, lat);

        // Random ops against the model
        for (int n = 0; n < 40; n++) begin
            rop = op_e'($urandom_range(0, 3));
            ra  = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
            case ($urandom_range(0, 7))
                0:       rb = '0;
                1:       rb = 32'($urandom_range(1, 15));
                2:       rb = 32'hFFFF_FFFF;
                3:       rb = 32'($urandom_range(0, 255));
                default: rb = $urandom;
            endcase
            model(rop, ra, rb, rhi, rlo);
            exec($sformatf("rnd%0d", n), rop, ra, rb, rhi, rlo, lat);
        end

`ifdef MULDIV_EARLY_OUT_EN
        exec("early_out", OP_MULTU, 32'd5, 32'd3, 32'd0, 32'd15, lat);
        checks++;
        if (lat > 4) begin
            errors++;
            $display("FAIL early_out_lat: latency %0d, required <= 4", lat);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Multi-cycle multiply/divide responder for the pipelined CPU's EX stage. Covers the long-latency counterpart of the single-cycle ALU path.
- The pipeline initiates an operation with a one-cycle start pulse. The unit runs iteratively and signals done, then holds the HI/LO registers for mfhi/mflo.
- busy drives the hazard unit to stall subsequent mfhi/mflo/mult/div.

Parameters:
- WIDTH, 32, operand and HI/LO width. Iteration count equals WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle request pulse, sampled only in IDLE.
- op  input  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- A  input  WIDTH  operand; dividend for DIV/DIVU.
- B  input  WIDTH  operand; divisor for DIV/DIVU.
- hi_we  input  1  mthi write enable.
- lo_we  input  1  mtlo write enable.
- wdata  input  WIDTH  data for mthi/mtlo.
- busy  output  1  high from the cycle after an accepted start until done.
- done  output  1  one-cycle pulse when HI/LO are updated with the result.
- hi  output  WIDTH  HI register: product high half or remainder.
- lo  output  WIDTH  LO register: product low half or quotient.

Behaviour:
- Reset is asynchronous and active-low, on port reset. While reset is low: state=IDLE; busy=0, done=0, hi=0, lo=0; internal counters and datapath regs are 0.
- FSM states are IDLE, CALC, FIX.
- IDLE → CALC when start=1.
  - Latch op and |A|, |B| for signed ops; raw values for unsigned ops.
  - Latch sign flags, set count=WIDTH, and drive busy=1 from the next cycle.
- CALC:
  - Multiply does one shift-add step per cycle on a 2*WIDTH accumulator.
  - Divide does one restoring step per cycle on the remainder/quotient pair.
  - count decrements each cycle. When count reaches 1, go to FIX.
- FIX (one cycle):
  - Apply sign correction. For MULT, negate the 64-bit product if sign(A)^sign(B).
  - For DIV, negate the quotient if sign(A)^sign(B); negate the remainder if sign(A).
  - Write hi/lo, pulse done=1, drop busy the same edge, return to IDLE.
- Fixed latency: start at edge N → done high in cycle N+WIDTH+1, i.e. 33 cycles after start for WIDTH=32.
- Divide by zero (B=0), both DIV and DIVU: lo=all ones, hi=A (original, uncorrected). Full latency, no exception.
- Most-negative operand (0x80000000) for signed ops: magnitude is handled as an unsigned WIDTH-bit value, so no overflow.
  - DIV 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0.
- start while busy is ignored. No queueing.
- hi_we/lo_we:
  - Honoured only in IDLE with start=0; update at the next edge.
  - If start and hi_we/lo_we are asserted in the same cycle, start wins and the write is dropped.
  - Writes while busy are dropped.
- hi/lo hold their previous values throughout CALC. They change only at FIX or on an accepted mthi/mtlo.
- If reset is asserted mid-operation, the operation is abandoned and all outputs return to their reset values immediately.

Optional Feature:
- Macro MULDIV_EARLY_OUT_EN.
- Defined:
  - Multiply leaves CALC for FIX as soon as the remaining multiplier bits are all zero, with the accumulator aligned by a final shift.
  - Latency is variable, between 2 and WIDTH+1 cycles.
  - Divide is unchanged.
- Undefined: fixed WIDTH+1 latency for all ops.
- hi/lo values must be identical either way.

Decomposition:
- Package muldiv_pkg holds:
  - op encodings: OP_MULT, OP_MULTU, OP_DIV, OP_DIVU.
  - state enum: IDLE, CALC, FIX.
  - localparam ITER=WIDTH.
- One sub-module: muldiv_sign_fix, a combinational block doing abs-value on entry and conditional negation of product/quotient/remainder on exit. It is instantiated twice, for entry and exit.

Test Plan:
- Reset low mid-CALC (cycle 10 of MULTU) → busy=0, done=0, hi=lo=0 immediately; next start behaves normally.
- MULTU A=0xFFFFFFFF, B=0xFFFFFFFF → done 33 cycles after start; hi=0xFFFFFFFE, lo=0x00000001.
- MULT A=0xFFFFFFFD (-3), B=7 → hi=0xFFFFFFFF, lo=0xFFFFFFEB (-21).
- DIV A=-7, B=2 → lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). DIVU A=100, B=0 → lo=0xFFFFFFFF, hi=100.
- start pulsed again at cycle 5 of a DIVU 100/7 → ignored; result lo=14, hi=2; exactly one done pulse.
- mthi 0x1234 in IDLE → hi=0x1234 next cycle. mtlo with start in the same cycle → lo takes the op result, not wdata. With MULDIV_EARLY_OUT_EN: MULTU 5*3 → hi=0, lo=15, done in ≤4 cycles.
